// File: rtl/dbus_arbiter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_arbiter_mc
//  Description : N-channel round-robin arbiter for the split-transaction data
//                bus (addr_ok/data_ok handshake). Keeps up to DEPTH in-order
//                outstanding transactions and routes each data_ok back to its
//                issuing channel through an owner-ID FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter_mc #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    // Upstream requester channels
    input  logic [N_CH-1:0]            m_valid,
    input  logic [N_CH*ADDR_W-1:0]     m_addr,
    input  logic [N_CH*3-1:0]          m_size,
    input  logic [N_CH*DATA_W/8-1:0]   m_strobe,
    input  logic [N_CH*DATA_W-1:0]     m_wdata,
    output logic [N_CH-1:0]            m_addr_ok,
    output logic [N_CH-1:0]            m_data_ok,
    output logic [DATA_W-1:0]          m_rdata,
    // Downstream bus
    output logic                       s_valid,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [2:0]                 s_size,
    output logic [DATA_W/8-1:0]        s_strobe,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addr_ok,
    input  logic                       s_data_ok,
    input  logic [DATA_W-1:0]          s_rdata,
    // Status
    output logic                       err_spur
);

    localparam int STRB_W = DATA_W / 8;
    localparam int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [ID_W-1:0]  LAST_CH  = ID_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Lock state: OPEN lets round-robin choose, HOLD pins the stalled grant
    typedef enum logic [0:0] {
        ST_OPEN = 1'b0,
        ST_HOLD = 1'b1
    } lock_state_t;

    lock_state_t       state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [ID_W-1:0]   fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_spur_q, err_spur_d;

    logic [ID_W-1:0]   w_gnt_rr;
    logic [ID_W:0]     w_cand_sum;
    logic              w_found;
    logic [ID_W-1:0]   w_gnt;
    logic              w_full;
    logic              w_empty;
    logic              w_fire;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_spur;
    logic [ID_W-1:0]   w_head;

    // Round-robin search: first valid channel at or after rr_ptr, wrapping
    always_comb begin
        w_gnt_rr   = rr_ptr_q;
        w_found    = 1'b0;
        w_cand_sum = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (w_cand_sum >= (ID_W+1)'(N_CH)) begin
                w_cand_sum = w_cand_sum - (ID_W+1)'(N_CH);
            end
            if (!w_found && m_valid[w_cand_sum[ID_W-1:0]]) begin
                w_gnt_rr = w_cand_sum[ID_W-1:0];
                w_found  = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant until the downstream accepts it
    assign w_gnt   = (state_q == ST_HOLD) ? lock_id_q : w_gnt_rr;
    assign w_full  = (count_q == FULL_CNT);
    assign w_empty = (count_q == '0);
    assign w_head  = fifo_q[rd_ptr_q];

    assign s_valid  = !reset && !w_full && (|m_valid) && m_valid[w_gnt];
    assign s_addr   = m_addr  [int'(w_gnt)*ADDR_W +: ADDR_W];
    assign s_size   = m_size  [int'(w_gnt)*3      +: 3];
    assign s_strobe = m_strobe[int'(w_gnt)*STRB_W +: STRB_W];
    assign s_wdata  = m_wdata [int'(w_gnt)*DATA_W +: DATA_W];

    assign w_fire   = s_valid && s_addr_ok;
    // Response in the same cycle as the issue on an empty FIFO needs no entry
    assign w_bypass = w_fire && s_data_ok && w_empty;
    assign w_push   = w_fire && !w_bypass;
    assign w_pop    = !reset && !w_empty && s_data_ok;
    assign w_spur   = w_empty && s_data_ok && !w_fire;

    assign m_rdata  = s_rdata;
    assign err_spur = err_spur_q;

    // Per-channel handshake decode (address accept and data return)
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (w_fire) begin
            m_addr_ok[w_gnt] = 1'b1;
        end
        if (w_pop) begin
            m_data_ok[w_head] = 1'b1;
        end else if (w_bypass) begin
            m_data_ok[w_gnt] = 1'b1;
        end
    end

    // Lock FSM next state: enter HOLD on a refused request, leave on accept
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        case (state_q)
            ST_OPEN: begin
                if (s_valid && !s_addr_ok) begin
                    state_d   = ST_HOLD;
                    lock_id_d = w_gnt;
                end
            end
            ST_HOLD: begin
                if (w_fire) begin
                    state_d = ST_OPEN;
                end
            end
            default: begin
                state_d = ST_OPEN;
            end
        endcase
    end

    // Round-robin pointer, FIFO pointers/count and sticky error next state
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_spur_d = err_spur_q | w_spur;
        if (w_fire) begin
            rr_ptr_d = (w_gnt == LAST_CH) ? '0 : w_gnt + 1'b1;
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_spur_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_spur_q <= err_spur_d;
        end
    end

    // Owner-ID storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_gnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_arbiter_mc
//  Description : Directed bench for dbus_arbiter_mc (N_CH=2, DEPTH=4) with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_arbiter_mc;

    localparam int N_CH   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0080;

    logic                     clk;
    logic                     reset;
    logic [N_CH-1:0]          m_valid;
    logic [N_CH*ADDR_W-1:0]   m_addr;
    logic [N_CH*3-1:0]        m_size;
    logic [N_CH*DATA_W/8-1:0] m_strobe;
    logic [N_CH*DATA_W-1:0]   m_wdata;
    logic [N_CH-1:0]          m_addr_ok;
    logic [N_CH-1:0]          m_data_ok;
    logic [DATA_W-1:0]        m_rdata;
    logic                     s_valid;
    logic [ADDR_W-1:0]        s_addr;
    logic [2:0]               s_size;
    logic [DATA_W/8-1:0]      s_strobe;
    logic [DATA_W-1:0]        s_wdata;
    logic                     s_addr_ok;
    logic                     s_data_ok;
    logic [DATA_W-1:0]        s_rdata;
    logic                     err_spur;

    int n_vec;
    int n_err;

    dbus_arbiter_mc #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_size    (m_size),
        .m_strobe  (m_strobe),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_size    (s_size),
        .s_strobe  (s_strobe),
        .s_wdata   (s_wdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .s_rdata   (s_rdata),
        .err_spur  (err_spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle; lands on the falling edge
    task automatic settle();
        #4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        m_valid   = 2'b11;
        m_addr    = {A1, A0};
        m_size    = {3'd2, 3'd1};
        m_strobe  = '0;
        m_wdata   = {32'h5555_AAAA, 32'h1234_5678};
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        s_rdata   = '0;

        // ---- 1: outputs gated during reset, then idle for 10 cycles ----
        #2;
        settle();
        check_val("rst_outs", {s_valid, m_addr_ok, m_data_ok}, 5'b0);
        tick();
        reset     = 1'b0;
        m_valid   = 2'b00;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            check_val("idle", {s_valid, m_addr_ok, m_data_ok, err_spur}, 6'b0);
            tick();
        end

        // ---- 2: contention, alternating grants, data_ok 2 cycles later ----
        s_addr_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            m_valid   = (c < 4) ? 2'b11 : 2'b00;
            s_data_ok = (c >= 2);
            s_rdata   = 32'hA000_0000 + 32'(c);
            settle();
            if (c < 4) begin
                check_val("cont_aok", m_addr_ok, (c % 2 == 1) ? 2'b10 : 2'b01);
                check_val("cont_addr", s_addr, (c % 2 == 1) ? A1 : A0);
            end else begin
                check_val("cont_aok", m_addr_ok, 2'b00);
            end
            if (c >= 2) begin
                check_val("cont_dok", m_data_ok, (c % 2 == 1) ? 2'b10 : 2'b01);
                check_val("cont_rdata", m_rdata, 32'hA000_0000 + 32'(c));
            end else begin
                check_val("cont_dok", m_data_ok, 2'b00);
            end
            tick();
        end
        s_data_ok = 1'b0;

        // ---- 3: stalled ch1 write holds the bus while ch0 arrives ----
        m_strobe  = {4'hF, 4'h0};
        s_addr_ok = 1'b0;
        for (int c = 0; c < 5; c++) begin
            m_valid   = (c == 0) ? 2'b10 : ((c == 4) ? 2'b01 : 2'b11);
            s_addr_ok = (c >= 3);
            settle();
            check_val("stall_svalid", s_valid, 1'b1);
            if (c < 4) begin
                check_val("stall_addr", s_addr, A1);
                check_val("stall_aok", m_addr_ok, (c == 3) ? 2'b10 : 2'b00);
            end else begin
                check_val("stall_aok2", m_addr_ok, 2'b01);
            end
            if (c == 1) begin
                check_val("stall_fields", {s_size, s_strobe, s_wdata}, {3'd2, 4'hF, 32'h5555_AAAA});
            end
            tick();
        end
        m_valid   = 2'b00;
        m_strobe  = '0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b1;
        settle();
        check_val("stall_dok1", m_data_ok, 2'b10);
        tick();
        settle();
        check_val("stall_dok2", m_data_ok, 2'b01);
        tick();
        s_data_ok = 1'b0;

        // ---- 4: depth limit, 5th read waits for one data_ok ----
        m_valid   = 2'b01;
        s_addr_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_val("depth_aok", m_addr_ok, 2'b01);
            tick();
        end
        settle();
        check_val("depth_full", {s_valid, m_addr_ok}, 3'b000);
        tick();
        s_data_ok = 1'b1;
        settle();
        check_val("depth_full_dok", {s_valid, m_data_ok}, 3'b001);
        tick();
        s_data_ok = 1'b0;
        settle();
        check_val("depth_5th", {s_valid, m_addr_ok}, 3'b101);
        tick();
        m_valid   = 2'b00;
        s_data_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            check_val("depth_drain", m_data_ok, 2'b01);
            tick();
        end
        s_data_ok = 1'b0;

        // ---- 5: bypass on empty FIFO, count stays zero ----
        m_valid   = 2'b01;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEAD_BEEF;
        settle();
        check_val("byp_ok", {m_addr_ok, m_data_ok}, 4'b0101);
        check_val("byp_rdata", m_rdata, 32'hDEAD_BEEF);
        tick();
        m_valid   = 2'b00;
        s_data_ok = 1'b0;
        settle();
        check_val("byp_nospur", err_spur, 1'b0);
        tick();
        s_data_ok = 1'b1;
        settle();
        check_val("byp_empty_dok", m_data_ok, 2'b00);
        tick();
        s_data_ok = 1'b0;
        settle();
        check_val("byp_empty_spur", err_spur, 1'b1);

        // ---- 6: async reset with 2 outstanding, then stray data_ok ----
        tick();
        reset = 1'b1;
        settle();
        tick();
        reset = 1'b0;
        settle();
        check_val("r6_clear", err_spur, 1'b0);
        tick();
        m_valid   = 2'b11;
        s_addr_ok = 1'b1;
        settle();
        check_val("r6_aok0", m_addr_ok, 2'b01);
        tick();
        settle();
        check_val("r6_aok1", m_addr_ok, 2'b10);
        tick();
        s_data_ok = 1'b1;
        #2;
        reset = 1'b1;
        #2;
        check_val("r6_gated", {s_valid, m_addr_ok, m_data_ok, err_spur}, 6'b0);
        tick();
        reset   = 1'b0;
        m_valid = 2'b00;
        settle();
        check_val("r6_nodok", m_data_ok, 2'b00);
        tick();
        s_data_ok = 1'b0;
        settle();
        check_val("r6_spur", err_spur, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
